// File: rtl/combo_lock_pkg.sv
// Shared types, status encodings and width helpers for the combination lock.
package combo_lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_LOCKOUT = 3'd3
  } state_t;

  localparam logic [1:0] Z_IDLE    = 2'b00;
  localparam logic [1:0] Z_ENTRY   = 2'b01;
  localparam logic [1:0] Z_OPEN    = 2'b10;
  localparam logic [1:0] Z_LOCKOUT = 2'b11;

  // Bit width needed to hold values 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [1:0] z_of(input state_t s);
    case (s)
      ST_ENTRY:   return Z_ENTRY;
      ST_OPEN:    return Z_OPEN;
      ST_LOCKOUT: return Z_LOCKOUT;
      default:    return Z_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sw_press_det.sv
// Registers the switch levels and flags a press on the 0 -> non-zero transition,
// split into valid (one-hot) and invalid (multi-hot) with the pressed index.
module sw_press_det
  import combo_lock_pkg::*;
#(
  parameter  int NUM_SW = 4,
  localparam int IDX_W  = clog2_min1(NUM_SW)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_SW-1:0] sw,
  output logic              press_valid,
  output logic              press_invalid,
  output logic [IDX_W-1:0]  press_idx
);

  logic [NUM_SW-1:0] sw_q;
  logic              press;

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sw_q <= '0;
    else          sw_q <= sw;
  end

  assign press         = (sw_q == '0) && (sw != '0);
  assign press_valid   = press && $onehot(sw);
  assign press_invalid = press && !$onehot(sw);

  // NOTE: combinational blocks assign a default first so no path leaves the
  // output unassigned, which would otherwise infer a latch.
  always_comb begin
    press_idx = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      if (sw[i]) press_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/combo_lock_fsm.sv
// Combination lock: matches a stored press sequence, opens for a bounded time,
// counts consecutive failures and enforces a timed lockout.
module combo_lock_fsm
  import combo_lock_pkg::*;
#(
  parameter  int NUM_SW        = 4,
  parameter  int SEQ_LEN       = 4,
  parameter  int MAX_FAIL      = 3,
  parameter  int LOCKOUT_CYC   = 16,
  parameter  int OPEN_CYC      = 32,
  parameter  int ENTRY_TIMEOUT = 64,
  localparam int SW_IDX_W      = clog2_min1(NUM_SW),
  localparam int CODE_IDX_W    = clog2_min1(SEQ_LEN),
  localparam int PROG_W        = clog2_min1(SEQ_LEN + 1),
  localparam int FAIL_W        = clog2_min1(MAX_FAIL + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_SW-1:0]     sw,
  input  logic                  relock,
  input  logic                  code_we,
  input  logic [CODE_IDX_W-1:0] code_idx,
  input  logic [SW_IDX_W-1:0]   code_data,
  output logic [2:0]            state,
  output logic [1:0]            z,
  output logic                  unlock,
  output logic [PROG_W-1:0]     progress,
  output logic [FAIL_W-1:0]     fail_cnt
);

  localparam int DWELL_W = clog2_min1(max3(LOCKOUT_CYC, OPEN_CYC, ENTRY_TIMEOUT) + 1);

  state_t               state_q, state_d;
  logic [PROG_W-1:0]    progress_d;
  logic [FAIL_W-1:0]    fail_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 unlock_d;
  logic                 press_valid, press_invalid, match;
  logic [SW_IDX_W-1:0]  press_idx, expected;
  logic [SW_IDX_W-1:0]  code_q [SEQ_LEN];

  sw_press_det #(.NUM_SW(NUM_SW)) u_press (
    .clk           (clk),
    .reset_n       (reset_n),
    .sw            (sw),
    .press_valid   (press_valid),
    .press_invalid (press_invalid),
    .press_idx     (press_idx)
  );

  // progress is 0 in IDLE, so one lookup serves both IDLE and ENTRY.
  assign expected = code_q[progress[CODE_IDX_W-1:0]];
  assign match    = press_valid && (press_idx == expected);

  always_comb begin
    state_d    = state_q;
    progress_d = progress;
    fail_d     = fail_cnt;
    case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (match) begin
          if (int'(progress) + 1 == SEQ_LEN) begin
            state_d    = ST_OPEN;
            progress_d = '0;
            fail_d     = '0;
          end else begin
            state_d    = ST_ENTRY;
            progress_d = progress + 1'b1;
          end
        end else if (press_valid || press_invalid) begin
          progress_d = '0;
          fail_d     = fail_cnt + 1'b1;
          state_d    = (int'(fail_cnt) + 1 >= MAX_FAIL) ? ST_LOCKOUT : ST_IDLE;
        end else if (state_q == ST_ENTRY && int'(dwell_q) >= ENTRY_TIMEOUT - 1) begin
          state_d    = ST_IDLE;
          progress_d = '0;
        end
      end
      ST_OPEN: begin
        if (relock || int'(dwell_q) >= OPEN_CYC - 1) state_d = ST_IDLE;
      end
      ST_LOCKOUT: begin
        if (int'(dwell_q) >= LOCKOUT_CYC - 1) begin
          state_d = ST_IDLE;
          fail_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    dwell_d = dwell_q;
    if (state_d != state_q || (state_q == ST_ENTRY && (press_valid || press_invalid)))
      dwell_d = '0;
    else if (dwell_q != '1)
      dwell_d = dwell_q + 1'b1;

    unlock_d = (state_d == ST_OPEN) && (state_q != ST_OPEN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      z        <= Z_IDLE;
      unlock   <= 1'b0;
      progress <= '0;
      fail_cnt <= '0;
      dwell_q  <= '0;
    end else begin
      state_q  <= state_d;
      z        <= z_of(state_d);
      unlock   <= unlock_d;
      progress <= progress_d;
      fail_cnt <= fail_d;
      dwell_q  <= dwell_d;
    end
  end

  // NOTE: this small code table is deliberately reset so the lock has a known
  // default combination; large data memories would normally be left unreset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SEQ_LEN; i++) code_q[i] <= SW_IDX_W'(i % NUM_SW);
    end else if (state_q == ST_OPEN && code_we && int'(code_idx) < SEQ_LEN) begin
      code_q[code_idx] <= code_data;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_combo_lock_fsm.sv
// Directed self-checking bench for combo_lock_fsm at default parameters.
module tb_combo_lock_fsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] sw;
  logic       relock;
  logic       code_we;
  logic [1:0] code_idx;
  logic [1:0] code_data;
  logic [2:0] state;
  logic [1:0] z;
  logic       unlock;
  logic [2:0] progress;
  logic [1:0] fail_cnt;

  int checks = 0;
  int errors = 0;

  combo_lock_fsm dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sw        (sw),
    .relock    (relock),
    .code_we   (code_we),
    .code_idx  (code_idx),
    .code_data (code_data),
    .state     (state),
    .z         (z),
    .unlock    (unlock),
    .progress  (progress),
    .fail_cnt  (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_st(input string tag, input logic [2:0] st, input logic [1:0] zz,
                          input logic [2:0] prog, input logic [1:0] fc);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".z"}, 32'(z), 32'(zz));
    check({tag, ".progress"}, 32'(progress), 32'(prog));
    check({tag, ".fail_cnt"}, 32'(fail_cnt), 32'(fc));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] v);
    sw = v;
    tick(1);
  endtask

  task automatic rel();
    sw = 4'b0000;
    tick(1);
  endtask

  initial begin
    reset_n = 1'b0; sw = '0; relock = 1'b0; code_we = 1'b0; code_idx = '0; code_data = '0;
    #12;
    check_st("reset", 3'd0, 2'b00, 3'd0, 2'd0);
    check("reset.unlock", 32'(unlock), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick(1);

    // Correct default code 0,1,2,3
    push(4'b0001); check_st("ok1", 3'd1, 2'b01, 3'd1, 2'd0); rel();
    push(4'b0010); check_st("ok2", 3'd1, 2'b01, 3'd2, 2'd0); rel();
    push(4'b0100); check_st("ok3", 3'd1, 2'b01, 3'd3, 2'd0); rel();
    push(4'b1000); check_st("ok4", 3'd2, 2'b10, 3'd0, 2'd0);
    check("ok4.unlock", 32'(unlock), 32'd1);
    rel();
    check("ok4.unlock_drop", 32'(unlock), 32'd0);
    check("ok4.still_open", 32'(state), 32'd2);
    relock = 1'b1; tick(1); relock = 1'b0;
    check_st("relock", 3'd0, 2'b00, 3'd0, 2'd0);

    // Three wrong attempts -> lockout, then timed exit
    for (int i = 0; i < 2; i++) begin
      push(4'b0001); rel(); push(4'b0100); rel();
      check_st("wrong", 3'd0, 2'b00, 3'd0, 2'(i + 1));
    end
    push(4'b0001); rel(); push(4'b0100);
    check_st("lockout", 3'd3, 2'b11, 3'd0, 2'd3);
    rel();
    push(4'b0001); check("lockout.ignore", 32'(state), 32'd3); rel();
    tick(12);
    check("lockout.15", 32'(state), 32'd3);
    tick(1);
    check_st("lockout.exit", 3'd0, 2'b00, 3'd0, 2'd0);

    // Multi-hot press, held press, switch change while held
    push(4'b0011); check_st("multihot", 3'd0, 2'b00, 3'd0, 2'd1); rel();
    push(4'b0001); check_st("hold.first", 3'd1, 2'b01, 3'd1, 2'd1);
    tick(9);       check_st("hold.10", 3'd1, 2'b01, 3'd1, 2'd1);
    push(4'b0010); check_st("hold.change", 3'd1, 2'b01, 3'd1, 2'd1);
    rel();
    push(4'b0010); check_st("prog2", 3'd1, 2'b01, 3'd2, 2'd1); rel();
    tick(62);      check_st("timeout.63", 3'd1, 2'b01, 3'd2, 2'd1);
    tick(1);       check_st("timeout.64", 3'd0, 2'b00, 3'd0, 2'd1);

    // Reprogram code[0]=3 in OPEN; writes in IDLE must be ignored
    push(4'b0001); rel(); push(4'b0010); rel(); push(4'b0100); rel(); push(4'b1000);
    check_st("open2", 3'd2, 2'b10, 3'd0, 2'd0);
    rel();
    push(4'b0001); check("open.ignore", 32'(state), 32'd2); rel();
    code_we = 1'b1; code_idx = 2'd0; code_data = 2'd3; tick(1); code_we = 1'b0;
    relock = 1'b1; tick(1); relock = 1'b0;
    check("relock2", 32'(state), 32'd0);
    code_we = 1'b1; code_idx = 2'd1; code_data = 2'd0; tick(1); code_we = 1'b0;
    push(4'b1000); check_st("new1", 3'd1, 2'b01, 3'd1, 2'd0); rel();
    push(4'b0010); check_st("new2", 3'd1, 2'b01, 3'd2, 2'd0); rel();
    push(4'b0100); check_st("new3", 3'd1, 2'b01, 3'd3, 2'd0); rel();
    push(4'b1000); check_st("new4", 3'd2, 2'b10, 3'd0, 2'd0);
    check("new4.unlock", 32'(unlock), 32'd1);
    rel();
    tick(30);      check("open.31", 32'(state), 32'd2);
    tick(1);       check("open.32", 32'(state), 32'd0);

    // relock coinciding with code_we: write lands, lock returns to IDLE
    push(4'b1000); rel(); push(4'b0010); rel(); push(4'b0100); rel(); push(4'b1000);
    check("open3", 32'(state), 32'd2);
    rel();
    relock = 1'b1; code_we = 1'b1; code_idx = 2'd0; code_data = 2'd0; tick(1);
    relock = 1'b0; code_we = 1'b0;
    check("relock_we", 32'(state), 32'd0);
    push(4'b0001); check_st("rewritten0", 3'd1, 2'b01, 3'd1, 2'd0); rel();

    // Reach lockout, then asynchronous reset mid-lockout
    push(4'b0001); check_st("f1", 3'd0, 2'b00, 3'd0, 2'd1); rel();
    push(4'b0100); check_st("f2", 3'd0, 2'b00, 3'd0, 2'd2); rel();
    push(4'b0100); check_st("f3", 3'd3, 2'b11, 3'd0, 2'd3);
    #2 reset_n = 1'b0;
    #1 check_st("async_rst", 3'd0, 2'b00, 3'd0, 2'd0);
    check("async_rst.unlock", 32'(unlock), 32'd0);
    #3 reset_n = 1'b1;
    sw = 4'b0000;
    tick(1);

    // Reset restores the default code
    push(4'b0001); rel(); push(4'b0010); rel(); push(4'b0100); rel(); push(4'b1000);
    check_st("default_code", 3'd2, 2'b10, 3'd0, 2'd0);
    rel();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/combo_lock_fsm.md
COMBO_LOCK_FSM -- requirements
Module: combo_lock_fsm

Interface
REQ-001 The parameter NUM_SW SHALL default to 4 and set the number of switch inputs (2..16).
REQ-002 The parameter SEQ_LEN SHALL default to 4 and set the number of presses in the unlock code (1..16).
REQ-003 The parameter MAX_FAIL SHALL default to 3 and set the consecutive failed attempts that trigger lockout.
REQ-004 The parameters LOCKOUT_CYC, OPEN_CYC and ENTRY_TIMEOUT SHALL default to 16, 32 and 64 and set the LOCKOUT, OPEN and ENTRY dwell limits in clocks.
REQ-005 The design SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk  in  1  SHALL be the sole clock; all state updates occur on its rising edge.
REQ-007 reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-008 sw  in  NUM_SW  SHALL carry the switch levels, already synchronous to clk and debounced.
REQ-009 relock  in  1  SHALL be a level input that forces OPEN back to IDLE.
REQ-010 code_we  in  1  SHALL be the code-write strobe, honoured only in OPEN.
REQ-011 code_idx  in  $clog2(SEQ_LEN) (min 1)  SHALL be the index of the code entry to write.
REQ-012 code_data  in  $clog2(NUM_SW) (min 1)  SHALL be the switch index to store in that entry.
REQ-013 state  out  3  SHALL report the current state: IDLE=0, ENTRY=1, OPEN=2, LOCKOUT=3.
REQ-014 z  out  2  SHALL report status: 00 idle, 01 entry in progress, 10 open, 11 lockout.
REQ-015 unlock  out  1  SHALL be a one-clock pulse on entry to OPEN.
REQ-016 progress  out  $clog2(SEQ_LEN+1)  SHALL report the count of correct presses in the current attempt.
REQ-017 fail_cnt  out  $clog2(MAX_FAIL+1)  SHALL report the count of consecutive failed attempts.

Function
REQ-018 sw SHALL be registered into sw_q every clock, including in OPEN and LOCKOUT.
REQ-019 A press SHALL occur when sw_q==0 and sw!=0; it is valid if sw is one-hot, invalid if multi-hot; the FSM acts on the same edge.
REQ-020 Holding, releasing, or changing switches while sw_q!=0 SHALL produce no press.
REQ-021 IDLE: a valid press equal to code[0] SHALL go to ENTRY with progress=1, or to OPEN if SEQ_LEN==1.
REQ-022 ENTRY: a valid press equal to code[progress] SHALL increment progress; the final match SHALL go to OPEN and clear fail_cnt and progress.
REQ-023 IDLE/ENTRY: a mismatched or invalid press SHALL clear progress, increment fail_cnt and go to IDLE, or to LOCKOUT when the incremented fail_cnt equals MAX_FAIL.
REQ-024 ENTRY: ENTRY_TIMEOUT consecutive clocks without a press SHALL return to IDLE with progress cleared and fail_cnt unchanged.
REQ-025 OPEN: presses SHALL be ignored; relock=1 or OPEN_CYC elapsed clocks SHALL go to IDLE; code_we SHALL write code[code_idx]<=code_data.
REQ-026 code_we SHALL be ignored outside OPEN and for code_idx>=SEQ_LEN; if relock and code_we coincide, the write SHALL complete and the state SHALL go to IDLE.
REQ-027 LOCKOUT: presses SHALL be ignored; after LOCKOUT_CYC clocks the state SHALL go to IDLE with fail_cnt cleared.
REQ-028 The single dwell counter SHALL clear on every state change and on each press in ENTRY, and SHALL saturate rather than wrap.
REQ-029 state, z, progress and fail_cnt SHALL be registered; unlock SHALL be registered and high only on the first OPEN clock.

Reset
REQ-030 Asserting reset_n low SHALL immediately force state=IDLE, z=00, unlock=0, progress=0, fail_cnt=0, sw_q=0 and dwell=0, including mid-attempt or mid-lockout.
REQ-031 Reset SHALL load code[i]=i mod NUM_SW; code entries SHALL change afterwards only through REQ-025.

Structure
REQ-032 The package combo_lock_pkg SHALL hold the state enum (3-bit), the z encodings and the width helper functions.
REQ-033 Press detection (sw_q, valid press, invalid press, index encode) SHALL be the sub-module sw_press_det, parameterised by NUM_SW.

Verification (defaults; code 0,1,2,3)
REQ-034 From reset, presses sw=0001,0010,0100,1000, each separated by sw=0, SHALL yield progress 1,2,3, then state=2, z=10, a one-clock unlock pulse and fail_cnt=0.
REQ-035 From IDLE, presses 0001 then 0100 SHALL yield state=0 and fail_cnt=1; three such failures SHALL give state=3 and z=11; after 16 clocks the result SHALL be state=0 and fail_cnt=0.
REQ-036 From IDLE, press sw=0011 SHALL count as an invalid press, giving fail_cnt+1; holding sw=0001 for 10 clocks SHALL count as one press only.
REQ-037 Unlock, then code_we with idx=0 and data=3, then relock SHALL return to IDLE; the sequence 1000,0010,0100,1000 SHALL then open; code_we while in IDLE SHALL not change the code.
REQ-038 In ENTRY with progress=2, 64 idle clocks SHALL give state=0, progress=0 and fail_cnt unchanged; reset_n pulsed low in LOCKOUT SHALL give state=0 and fail_cnt=0 immediately.
